// File: rtl/edge_pkg.sv
// Shared edge-mode encodings and sizing helpers for multi_edge_capture.
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One trigger channel: synchroniser, history flop, mode filter and one-deep holding register.
// EDGE_TIMESTAMP_EN adds a timestamp field to the holding register.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
`ifdef EDGE_TIMESTAMP_EN
    ,
    parameter int unsigned TS_W        = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              drain,
`ifdef EDGE_TIMESTAMP_EN
    input  logic [TS_W-1:0]   ts,
    output logic [TS_W-1:0]   hold_ts,
`endif
    output logic              pending,
    output logic              ovf_set_c,
    output logic [DATA_W-1:0] hold_data,
    output logic              hold_rising
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;
    logic                   sync_out;
    logic                   rise_c;
    logic                   det_c;
    logic                   capture_c;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
            hist   <= sync_out;
        end
    end

    // A drain in the same cycle frees the slot, so a coincident edge is captured, not dropped.
    always_comb begin
        rise_c = sync_out & ~hist;
        det_c  = 1'b0;
        if (sync_out != hist) begin
            case (mode)
                EDGE_RISE: det_c = rise_c;
                EDGE_FALL: det_c = ~rise_c;
                EDGE_BOTH: det_c = 1'b1;
                default:   det_c = 1'b0;
            endcase
        end
        capture_c = det_c & (~pending | drain);
        ovf_set_c = det_c & pending & ~drain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            hold_data   <= '0;
            hold_rising <= 1'b0;
`ifdef EDGE_TIMESTAMP_EN
            hold_ts     <= '0;
`endif
        end else if (capture_c) begin
            pending     <= 1'b1;
            hold_data   <= data;
            hold_rising <= rise_c;
`ifdef EDGE_TIMESTAMP_EN
            hold_ts     <= ts;
`endif
        end else if (drain) begin
            pending     <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_edge_capture.sv
// Multi-channel edge capture with round-robin drain to a valid/ready event port.
// EDGE_TIMESTAMP_EN adds a free-running timestamp stored per event and the evt_ts port.
module multi_edge_capture
    import edge_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TS_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          trigger,
    input  logic [CHANNELS*DATA_W-1:0]   data,
    input  logic [2*CHANNELS-1:0]        edge_mode,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [chan_w(CHANNELS)-1:0]  evt_chan,
    output logic [DATA_W-1:0]            evt_data,
    output logic                         evt_rising,
`ifdef EDGE_TIMESTAMP_EN
    output logic [TS_W-1:0]              evt_ts,
`endif
    output logic [CHANNELS-1:0]          ovf,
    input  logic [CHANNELS-1:0]          ovf_clr
);

    localparam int unsigned CW = chan_w(CHANNELS);

    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] ovf_set_c;
    logic [CHANNELS-1:0] drain_c;
    logic [CHANNELS-1:0] hold_rising;
    logic [DATA_W-1:0]   hold_data [CHANNELS];
    logic [CW-1:0]       ptr_q;
    logic [CW-1:0]       grant_c;
    logic [CW-1:0]       ptr_next_c;
    logic                found_c;
    logic                load_c;
    int unsigned         cand;

`ifdef EDGE_TIMESTAMP_EN
    logic [TS_W-1:0]     ts_q;
    logic [TS_W-1:0]     hold_ts [CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_chan #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_TIMESTAMP_EN
            ,
            .TS_W        (TS_W)
`endif
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .trigger     (trigger[i]),
            .data        (data[i*DATA_W +: DATA_W]),
            .mode        (edge_mode[2*i +: 2]),
            .drain       (drain_c[i]),
`ifdef EDGE_TIMESTAMP_EN
            .ts          (ts_q),
            .hold_ts     (hold_ts[i]),
`endif
            .pending     (pending[i]),
            .ovf_set_c   (ovf_set_c[i]),
            .hold_data   (hold_data[i]),
            .hold_rising (hold_rising[i])
        );
    end

    // Round-robin search from the channel after the last grant.
    always_comb begin
        load_c  = ~evt_valid | evt_ready;
        found_c = 1'b0;
        grant_c = '0;
        drain_c = '0;
        cand    = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= CHANNELS) cand = cand - CHANNELS;
            if (!found_c && pending[CW'(cand)]) begin
                found_c = 1'b1;
                grant_c = CW'(cand);
            end
        end
        if (load_c && found_c) drain_c[grant_c] = 1'b1;
        ptr_next_c = (32'(grant_c) == CHANNELS - 1) ? '0 : grant_c + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid  <= 1'b0;
            evt_chan   <= '0;
            evt_data   <= '0;
            evt_rising <= 1'b0;
            ptr_q      <= '0;
`ifdef EDGE_TIMESTAMP_EN
            evt_ts     <= '0;
`endif
        end else if (load_c) begin
            evt_valid <= found_c;
            if (found_c) begin
                evt_chan   <= grant_c;
                evt_data   <= hold_data[grant_c];
                evt_rising <= hold_rising[grant_c];
                ptr_q      <= ptr_next_c;
`ifdef EDGE_TIMESTAMP_EN
                evt_ts     <= hold_ts[grant_c];
`endif
            end
        end
    end

    // Sticky overflow; a new overflow outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf <= '0;
        else        ovf <= (ovf & ~ovf_clr) | ovf_set_c;
    end

endmodule

// File: tb/tb_multi_edge_capture.sv
// Directed bench for multi_edge_capture with hand-computed expectations.
module tb_multi_edge_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  trigger;
    logic [31:0] data;
    logic [7:0]  edge_mode;
    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_chan;
    logic [7:0]  evt_data;
    logic        evt_rising;
`ifdef EDGE_TIMESTAMP_EN
    logic [15:0] evt_ts;
    logic [15:0] ts1;
    logic [15:0] ts2;
`endif
    logic [3:0]  ovf;
    logic [3:0]  ovf_clr;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multi_edge_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .data       (data),
        .edge_mode  (edge_mode),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_chan   (evt_chan),
        .evt_data   (evt_data),
        .evt_rising (evt_rising),
`ifdef EDGE_TIMESTAMP_EN
        .evt_ts     (evt_ts),
`endif
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        trigger   = '0;
        data      = '0;
        edge_mode = '0;
        ovf_clr   = '0;
        evt_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        trigger   = '0;
        data      = '0;
        edge_mode = '0;
        ovf_clr   = '0;
        evt_ready = 1'b1;
        tick();
        tick();
        check("rst_valid",  32'(evt_valid),  0);
        check("rst_chan",   32'(evt_chan),   0);
        check("rst_data",   32'(evt_data),   0);
        check("rst_rising", 32'(evt_rising), 0);
        check("rst_ovf",    32'(ovf),        0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        // Single rising edge on ch0: event exactly four cycles later, for one cycle.
        edge_mode  = 8'h01;
        data[7:0]  = 8'hEE;
        trigger[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("t1_valid_c%0d", c), 32'(evt_valid), 32'(c == 4));
            if (c == 4) begin
                check("t1_chan",   32'(evt_chan),   0);
                check("t1_data",   32'(evt_data),   32'hEE);
                check("t1_rising", 32'(evt_rising), 1);
            end
        end

        // Both-edge mode on ch1: rise and fall events ten cycles apart.
        edge_mode  = 8'h0D;
        data[15:8] = 8'h55;
        trigger[1] = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 10) trigger[1] = 1'b0;
            check($sformatf("t2_valid_c%0d", c), 32'(evt_valid), 32'(c == 4 || c == 14));
            if (c == 4 || c == 14) begin
                check("t2_chan",   32'(evt_chan),   1);
                check("t2_data",   32'(evt_data),   32'h55);
                check("t2_rising", 32'(evt_rising), 32'(c == 4));
            end
        end

        // All four channels rise together: drained 0,1,2,3 back to back.
        do_reset();
        edge_mode = 8'h55;
        data      = 32'h44332211;
        trigger   = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("t3_valid_c%0d", c), 32'(evt_valid), 32'(c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) begin
                check($sformatf("t3_chan_c%0d", c), 32'(evt_chan), 32'(c - 4));
                check($sformatf("t3_data_c%0d", c), 32'(evt_data), 32'(8'h11 * (c - 3)));
            end
        end

        // Stalled consumer, three edges on ch2: overflow, oldest data kept, clear.
        do_reset();
        edge_mode   = 8'h30;
        evt_ready   = 1'b0;
        data[23:16] = 8'hA1;
        trigger[2]  = 1'b1;
        repeat (4) tick();
        check("t4_valid1", 32'(evt_valid), 1);
        check("t4_data1",  32'(evt_data),  32'hA1);
        data[23:16] = 8'hA2;
        trigger[2]  = 1'b0;
        repeat (4) tick();
        check("t4_ovf_none", 32'(ovf),      0);
        check("t4_hold_a",   32'(evt_data), 32'hA1);
        data[23:16] = 8'hA3;
        trigger[2]  = 1'b1;
        repeat (4) tick();
        check("t4_ovf_set", 32'(ovf),        32'h4);
        check("t4_valid2",  32'(evt_valid),  1);
        check("t4_chan",    32'(evt_chan),   2);
        check("t4_hold_b",  32'(evt_data),   32'hA1);
        check("t4_rising",  32'(evt_rising), 1);
        ovf_clr = 4'h4;
        tick();
        ovf_clr = 4'h0;
        check("t4_ovf_clr", 32'(ovf), 0);
        evt_ready = 1'b1;
        tick();
        check("t4_next_valid",  32'(evt_valid),  1);
        check("t4_next_chan",   32'(evt_chan),   2);
        check("t4_next_data",   32'(evt_data),   32'hA2);
        check("t4_next_rising", 32'(evt_rising), 0);
        tick();
        check("t4_drained", 32'(evt_valid), 0);

        // Reset mid-stream with a held event and another pending.
        do_reset();
        edge_mode  = 8'h05;
        evt_ready  = 1'b0;
        data[7:0]  = 8'hEE;
        data[15:8] = 8'h77;
        trigger    = 4'h3;
        repeat (5) tick();
        check("t5_held_valid", 32'(evt_valid), 1);
        check("t5_held_data",  32'(evt_data),  32'hEE);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(evt_valid), 0);
        trigger = 4'h0;
        tick();
        check("t5_rst_valid",  32'(evt_valid),  0);
        check("t5_rst_chan",   32'(evt_chan),   0);
        check("t5_rst_data",   32'(evt_data),   0);
        check("t5_rst_rising", 32'(evt_rising), 0);
        check("t5_rst_ovf",    32'(ovf),        0);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("t5_stale_c%0d", c), 32'(evt_valid), 0);
        end

`ifdef EDGE_TIMESTAMP_EN
        // Two ch0 rising edges 100 cycles apart.
        do_reset();
        edge_mode  = 8'h01;
        trigger[0] = 1'b1;
        ts1 = '0;
        ts2 = '0;
        for (int c = 1; c <= 104; c++) begin
            tick();
            if (c == 50)  trigger[0] = 1'b0;
            if (c == 100) trigger[0] = 1'b1;
            if (c == 4) begin
                check("t6_valid1", 32'(evt_valid), 1);
                ts1 = evt_ts;
            end
            if (c == 104) begin
                check("t6_valid2", 32'(evt_valid), 1);
                ts2 = evt_ts;
            end
        end
        check("t6_ts_delta", 32'(16'(ts2 - ts1)), 100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_edge_capture.md
# multi_edge_capture

Parametrised successor to the single-channel trigger edge detector: watches CHANNELS asynchronous trigger lines and detects edges in a per-channel selectable mode (rise/fall/both/off). On each detected edge it captures that channel's data word. Captured events are queued one deep per channel and drained round-robin through a valid/ready output port. Sits between the board-level trigger inputs and the client packetiser.

## Interface
- CHANNELS, 4: number of trigger/data channels (1..16).
- DATA_W, 8: captured data width per channel.
- SYNC_STAGES, 2: trigger synchroniser depth (≥2).
- TS_W, 16: timestamp width (used only with EDGE_TIMESTAMP_EN).
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- trigger  in  CHANNELS  asynchronous trigger lines.
- data  in  CHANNELS*DATA_W  channel data; channel i at bits [i*DATA_W +: DATA_W].
- edge_mode  in  2*CHANNELS  per-channel mode: 00 off, 01 rise, 10 fall, 11 both.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_chan  out  clog2(CHANNELS) (min 1)  source channel.
- evt_data  out  DATA_W  data captured at detection.
- evt_rising  out  1  1 = rising edge, 0 = falling.
- evt_ts  out  TS_W  timestamp at detection (EDGE_TIMESTAMP_EN only).
- ovf  out  CHANNELS  sticky per-channel overflow.
- ovf_clr  in  CHANNELS  per-channel overflow clear pulse.

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, then one history flop. An edge is sync_out != hist, filtered by edge_mode.
- data is sampled on the same clock edge that captures the event into the channel holding register.
- Holding register (one entry per channel): pending, data, rising, (ts).
  - Edge while not pending: capture, pending=1.
  - Edge while pending and not being drained this cycle: event dropped, oldest kept, ovf[i] set.
  - Edge in the same cycle the entry is drained: new event captured, no overflow.
- Output register loads when empty, or when evt_valid && evt_ready (no bubble, one event per cycle).
- Round-robin arbiter: search starts at last granted channel +1, wraps at CHANNELS-1→0. After reset the pointer starts at channel 0.
- ovf: ovf_clr and a new overflow in the same cycle leave the bit set (set wins).
- edge_mode changes apply from the next detection. Mode 00 does not flush pending or output entries.
- The synchroniser and history flops reset to 0, so a trigger high at reset release is reported as one rising edge (if enabled).

## Timing
- Reset values: evt_valid=0, evt_chan=0, evt_data=0, evt_rising=0, evt_ts=0, ovf=0; all pending flags 0; arbiter pointer 0.
- Latency: trigger change sampled at clock edge k → pending at edge k+SYNC_STAGES → evt_valid high after edge k+SYNC_STAGES+1 (4 cycles at default).
- While evt_valid && !evt_ready, evt_chan, evt_data, evt_rising and evt_ts hold stable.
- Trigger pulses shorter than one clk period may be missed. This is documented, not an error.
- Reset asserted mid-operation clears all pending and output state immediately. Queued events are lost.

## Configuration
- EDGE_TIMESTAMP_EN defined: a free-running TS_W counter (reset 0, wraps at 2^TS_W-1→0). Its value at the detection cycle is stored per entry and presented on evt_ts.
- EDGE_TIMESTAMP_EN undefined: no counter, no ts storage, no evt_ts port.

## Structure
- Package edge_pkg: mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11; channel-index width function.
- Sub-module edge_chan: synchroniser, history flop, mode filter and holding register for one channel, with a drain input and a pending/ovf_set output. Instantiated CHANNELS times.
- The top level holds the arbiter, output register and timestamp counter.

## Test plan
- Reset, ch0 mode 01, trigger[0] 0→1 with data[7:0]=8'hEE, evt_ready=1 → evt_valid 4 cycles later for one cycle with chan=0, data=8'hEE, rising=1.
- ch1 mode 11, pulse trigger[1] high for 10 cycles with data 8'h55 → two events: rising=1, then rising=0, 10 cycles apart.
- Four channels mode 01, all triggers rise in the same cycle, evt_ready=1 → chan 0,1,2,3 on consecutive cycles, no gaps.
- evt_ready=0, ch2 edges three times → one event held, ovf[2]=1 and the first-captured data kept. ovf_clr[2] pulse → ovf[2]=0.
- Event pending with evt_valid && !evt_ready, assert rst_n=0 mid-stream → all outputs 0 next cycle, no stale event after release.
- With EDGE_TIMESTAMP_EN: two ch0 rising edges 100 cycles apart → evt_ts difference = 100.
